// File: rtl/cu_pkg.sv
// Shared encodings for the ctrl_unit_p sequencer: opcodes, state codes,
// ALU mode codes and MAR source selects.
package cu_pkg;

    localparam int unsigned ST_W   = 5;
    localparam int unsigned MODE_W = 3;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b00001;
    localparam logic [4:0] OP_MI  = 5'b00010;
    localparam logic [4:0] OP_MR  = 5'b00011;
    localparam logic [4:0] OP_SUM = 5'b00100;
    localparam logic [4:0] OP_SB  = 5'b00101;
    localparam logic [4:0] OP_ANR = 5'b00110;
    localparam logic [4:0] OP_CM  = 5'b00111;
    localparam logic [4:0] OP_ORR = 5'b01000;
    localparam logic [4:0] OP_ORI = 5'b01001;
    localparam logic [4:0] OP_XRR = 5'b01010;
    localparam logic [4:0] OP_XRI = 5'b01011;
    localparam logic [4:0] OP_SMI = 5'b01100;
    localparam logic [4:0] OP_SBI = 5'b01101;
    localparam logic [4:0] OP_ANI = 5'b01110;
    localparam logic [4:0] OP_CMI = 5'b01111;
    localparam logic [4:0] OP_JMP = 5'b10000;
    localparam logic [4:0] OP_JZ  = 5'b10001;
    localparam logic [4:0] OP_JC  = 5'b10010;
    localparam logic [4:0] OP_HLT = 5'b10011;

    typedef enum logic [ST_W-1:0] {
        S_F0 = 5'd0, S_F1, S_F2, S_DEC, S_I0, S_I1,
        S_LD0, S_LD1, S_LD2, S_ST0, S_ST1, S_ST2,
        S_MI, S_MR0, S_AL0, S_AL1, S_WB, S_JP, S_HALT
    } state_t;

    localparam logic [MODE_W-1:0] MODE_ADD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SUB  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_CMP  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_AND  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_PASS = 3'b111;

    localparam logic [1:0] RAM_SRC_PC  = 2'b00;
    localparam logic [1:0] RAM_SRC_MBR = 2'b01;

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier: instruction length, immediate/write-back attributes,
// ALU mode and the state that begins execution.
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0]  opcode,
    output logic              two_word,
    output logic              is_imm,
    output logic              writes_back,
    output logic [MODE_W-1:0] alu_mode,
    output logic [ST_W-1:0]   exec_state,
    output logic              illegal
);

    always_comb begin
        two_word    = 1'b0;
        is_imm      = 1'b0;
        writes_back = 1'b0;
        alu_mode    = MODE_PASS;
        exec_state  = S_F0;
        illegal     = 1'b0;
        case (opcode)
            OPC_W'(OP_LD):  begin two_word = 1'b1; exec_state = S_LD0; end
            OPC_W'(OP_ST):  begin two_word = 1'b1; exec_state = S_ST0; end
            OPC_W'(OP_MI):  begin two_word = 1'b1; exec_state = S_MI;  end
            OPC_W'(OP_MR):  begin writes_back = 1'b1; exec_state = S_MR0; end
            OPC_W'(OP_SUM): begin writes_back = 1'b1; alu_mode = MODE_ADD; exec_state = S_AL0; end
            OPC_W'(OP_SB):  begin writes_back = 1'b1; alu_mode = MODE_SUB; exec_state = S_AL0; end
            OPC_W'(OP_ANR): begin writes_back = 1'b1; alu_mode = MODE_AND; exec_state = S_AL0; end
            OPC_W'(OP_CM):  begin alu_mode = MODE_CMP; exec_state = S_AL0; end
            OPC_W'(OP_ORR): begin writes_back = 1'b1; alu_mode = MODE_OR;  exec_state = S_AL0; end
            OPC_W'(OP_XRR): begin writes_back = 1'b1; alu_mode = MODE_XOR; exec_state = S_AL0; end
            OPC_W'(OP_ORI): begin
                two_word = 1'b1; is_imm = 1'b1; writes_back = 1'b1;
                alu_mode = MODE_OR; exec_state = S_AL0;
            end
            OPC_W'(OP_XRI): begin
                two_word = 1'b1; is_imm = 1'b1; writes_back = 1'b1;
                alu_mode = MODE_XOR; exec_state = S_AL0;
            end
            OPC_W'(OP_SMI): begin
                two_word = 1'b1; is_imm = 1'b1; writes_back = 1'b1;
                alu_mode = MODE_ADD; exec_state = S_AL0;
            end
            OPC_W'(OP_SBI): begin
                two_word = 1'b1; is_imm = 1'b1; writes_back = 1'b1;
                alu_mode = MODE_SUB; exec_state = S_AL0;
            end
            OPC_W'(OP_ANI): begin
                two_word = 1'b1; is_imm = 1'b1; writes_back = 1'b1;
                alu_mode = MODE_AND; exec_state = S_AL0;
            end
            OPC_W'(OP_CMI): begin
                two_word = 1'b1; is_imm = 1'b1;
                alu_mode = MODE_CMP; exec_state = S_AL0;
            end
            OPC_W'(OP_JMP), OPC_W'(OP_JZ), OPC_W'(OP_JC): begin
                two_word = 1'b1; exec_state = S_JP;
            end
            OPC_W'(OP_HLT): exec_state = S_HALT;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_p.sv
// Multi-cycle control unit: fetch, optional second-word fetch, decode and
// execute, with strobes decoded from the current state and the IR fields.
module ctrl_unit_p
    import cu_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned REG_SEL_W = 3
) (
    input  logic                 cu_clk,
    input  logic                 cu_rst_n,
    input  logic [DATA_W-1:0]    cu_in,
    input  logic                 zero,
    input  logic                 carry,
    output logic [2:0]           mode,
    output logic [REG_SEL_W-1:0] select,
    output logic [4:0]           state,
    output logic [1:0]           RAM_in,
    output logic                 MBR_we,
    output logic                 IR_we,
    output logic                 PC_inc,
    output logic                 PC_load,
    output logic                 RF_we,
    output logic                 Acc_we,
    output logic                 MAR_we,
    output logic                 RAM_we,
    output logic                 ALU_mux,
    output logic                 RF_mux,
    output logic                 ALU_out_mux,
    output logic                 MBR_mux,
    output logic                 data_imm,
    output logic                 halted,
    output logic                 illegal_op
);

    logic [OPC_W-1:0]     opcode;
    logic [REG_SEL_W-1:0] dst;
    logic [REG_SEL_W-1:0] src;
    logic                 unused_in;

    assign opcode    = cu_in[DATA_W-1 -: OPC_W];
    assign dst       = cu_in[2*REG_SEL_W-1 -: REG_SEL_W];
    assign src       = cu_in[REG_SEL_W-1:0];
    assign unused_in = ^cu_in;

    logic              two_word;
    logic              is_imm;
    logic              writes_back;
    logic [MODE_W-1:0] alu_mode;
    logic [ST_W-1:0]   exec_state;
    logic              illegal;

    cu_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode      (opcode),
        .two_word    (two_word),
        .is_imm      (is_imm),
        .writes_back (writes_back),
        .alu_mode    (alu_mode),
        .exec_state  (exec_state),
        .illegal     (illegal)
    );

    state_t cur;
    logic   flag_z;
    logic   flag_c;

    // Sequencer; flags are captured only on the edge that leaves AL1.
    always_ff @(posedge cu_clk or negedge cu_rst_n) begin
        if (!cu_rst_n) begin
            cur    <= S_F0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (cur)
                S_F0:   cur <= S_F1;
                S_F1:   cur <= S_F2;
                S_F2:   cur <= S_DEC;
                S_DEC:  cur <= two_word ? S_I0 : state_t'(exec_state);
                S_I0:   cur <= S_I1;
                S_I1:   cur <= state_t'(exec_state);
                S_LD0:  cur <= S_LD1;
                S_LD1:  cur <= S_LD2;
                S_LD2:  cur <= S_F0;
                S_ST0:  cur <= S_ST1;
                S_ST1:  cur <= S_ST2;
                S_ST2:  cur <= S_F0;
                S_MI:   cur <= S_F0;
                S_MR0:  cur <= S_WB;
                S_AL0:  cur <= S_AL1;
                S_AL1: begin
                    flag_z <= zero;
                    flag_c <= carry;
                    cur    <= writes_back ? S_WB : S_F0;
                end
                S_WB:   cur <= S_F0;
                S_JP:   cur <= S_F0;
                S_HALT: cur <= S_HALT;
                default: cur <= S_F0;
            endcase
        end
    end

    assign state = cur;

    // Strobes are forced quiet while reset is held, so an aborted step drops at once.
    always_comb begin
        mode        = MODE_PASS;
        select      = '0;
        RAM_in      = RAM_SRC_PC;
        MBR_we      = 1'b0;
        IR_we       = 1'b0;
        PC_inc      = 1'b0;
        PC_load     = 1'b0;
        RF_we       = 1'b0;
        Acc_we      = 1'b0;
        MAR_we      = 1'b0;
        RAM_we      = 1'b0;
        ALU_mux     = 1'b0;
        RF_mux      = 1'b0;
        ALU_out_mux = 1'b0;
        MBR_mux     = 1'b0;
        data_imm    = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        if (cu_rst_n) begin
            case (cur)
                S_F0, S_I0: MAR_we = 1'b1;
                S_F1, S_I1: begin
                    MBR_we = 1'b1;
                    PC_inc = 1'b1;
                end
                S_F2:  IR_we = 1'b1;
                S_DEC: illegal_op = illegal;
                S_LD0, S_ST0: begin
                    MAR_we = 1'b1;
                    RAM_in = RAM_SRC_MBR;
                end
                S_LD1: MBR_we = 1'b1;
                S_LD2, S_MI: begin
                    RF_we    = 1'b1;
                    data_imm = 1'b1;
                    select   = dst;
                end
                S_ST1: begin
                    MBR_we  = 1'b1;
                    MBR_mux = 1'b1;
                    select  = dst;
                end
                S_ST2: RAM_we = 1'b1;
                S_MR0: begin
                    Acc_we      = 1'b1;
                    ALU_out_mux = 1'b1;
                    select      = src;
                end
                S_AL0: begin
                    Acc_we      = 1'b1;
                    ALU_out_mux = 1'b1;
                    select      = dst;
                end
                S_AL1: begin
                    Acc_we   = 1'b1;
                    mode     = alu_mode;
                    select   = src;
                    ALU_mux  = is_imm;
                    data_imm = is_imm;
                end
                S_WB: begin
                    RF_we  = 1'b1;
                    RF_mux = 1'b1;
                    select = dst;
                end
                S_JP: PC_load = (opcode == OPC_W'(OP_JMP))
                             | ((opcode == OPC_W'(OP_JZ)) & flag_z)
                             | ((opcode == OPC_W'(OP_JC)) & flag_c);
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit_p.sv
// Self-checking bench for ctrl_unit_p: per-cycle expected state/strobe
// records are queued with their stimulus and compared on the falling edge.
module tb_ctrl_unit_p;
    import cu_pkg::*;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_SEL_W = 3;

    localparam logic [14:0] K_MBR    = 15'h4000;
    localparam logic [14:0] K_IR     = 15'h2000;
    localparam logic [14:0] K_PCI    = 15'h1000;
    localparam logic [14:0] K_PCL    = 15'h0800;
    localparam logic [14:0] K_RF     = 15'h0400;
    localparam logic [14:0] K_ACC    = 15'h0200;
    localparam logic [14:0] K_MAR    = 15'h0100;
    localparam logic [14:0] K_RAM    = 15'h0080;
    localparam logic [14:0] K_AMUX   = 15'h0040;
    localparam logic [14:0] K_RFMUX  = 15'h0020;
    localparam logic [14:0] K_AOUT   = 15'h0010;
    localparam logic [14:0] K_MBRMUX = 15'h0008;
    localparam logic [14:0] K_IMM    = 15'h0004;
    localparam logic [14:0] K_HALT   = 15'h0002;
    localparam logic [14:0] K_ILL    = 15'h0001;

    typedef struct packed {
        logic [4:0]  st;
        logic [2:0]  mode;
        logic [2:0]  sel;
        logic [1:0]  ri;
        logic [14:0] stb;
    } obs_t;

    typedef struct packed {
        logic        load;
        logic [15:0] din;
        logic        z;
        logic        c;
        obs_t        exp;
    } ent_t;

    logic                 cu_clk = 1'b0;
    logic                 cu_rst_n;
    logic [DATA_W-1:0]    cu_in;
    logic                 zero, carry;
    logic [2:0]           mode;
    logic [REG_SEL_W-1:0] select;
    logic [4:0]           state;
    logic [1:0]           RAM_in;
    logic MBR_we, IR_we, PC_inc, PC_load, RF_we, Acc_we, MAR_we, RAM_we;
    logic ALU_mux, RF_mux, ALU_out_mux, MBR_mux, data_imm, halted, illegal_op;

    obs_t obs;
    ent_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ctrl_unit_p #(.DATA_W(DATA_W), .OPC_W(OPC_W), .REG_SEL_W(REG_SEL_W)) dut (
        .cu_clk(cu_clk), .cu_rst_n(cu_rst_n), .cu_in(cu_in),
        .zero(zero), .carry(carry), .mode(mode), .select(select),
        .state(state), .RAM_in(RAM_in), .MBR_we(MBR_we), .IR_we(IR_we),
        .PC_inc(PC_inc), .PC_load(PC_load), .RF_we(RF_we), .Acc_we(Acc_we),
        .MAR_we(MAR_we), .RAM_we(RAM_we), .ALU_mux(ALU_mux), .RF_mux(RF_mux),
        .ALU_out_mux(ALU_out_mux), .MBR_mux(MBR_mux), .data_imm(data_imm),
        .halted(halted), .illegal_op(illegal_op)
    );

    assign obs = {state, mode, select, RAM_in, MBR_we, IR_we, PC_inc, PC_load,
                  RF_we, Acc_we, MAR_we, RAM_we, ALU_mux, RF_mux, ALU_out_mux,
                  MBR_mux, data_imm, halted, illegal_op};

    always #5 cu_clk = ~cu_clk;

    function automatic obs_t rec(state_t s, logic [2:0] m, logic [2:0] sel,
                                 logic [1:0] ri, logic [14:0] stb);
        obs_t r;
        r.st = s; r.mode = m; r.sel = sel; r.ri = ri; r.stb = stb;
        return r;
    endfunction

    function automatic logic [15:0] enc(logic [4:0] op, logic [2:0] d, logic [2:0] s);
        return {op, 5'b00000, d, s};
    endfunction

    task automatic push(state_t s, logic [2:0] m, logic [2:0] sel,
                        logic [1:0] ri, logic [14:0] stb);
        ent_t e;
        e.load = 1'b0; e.din = '0; e.z = 1'b0; e.c = 1'b0;
        e.exp = rec(s, m, sel, ri, stb);
        sb_q.push_back(e);
    endtask

    // F0 entry also carries the instruction word and flag inputs to drive.
    task automatic push_fetch(logic [15:0] din, logic z, logic c, logic ill);
        ent_t e;
        e.load = 1'b1; e.din = din; e.z = z; e.c = c;
        e.exp = rec(S_F0, MODE_PASS, 3'd0, RAM_SRC_PC, K_MAR);
        sb_q.push_back(e);
        push(S_F1, MODE_PASS, 3'd0, RAM_SRC_PC, K_MBR | K_PCI);
        push(S_F2, MODE_PASS, 3'd0, RAM_SRC_PC, K_IR);
        push(S_DEC, MODE_PASS, 3'd0, RAM_SRC_PC, ill ? K_ILL : 15'd0);
    endtask

    task automatic push_second();
        push(S_I0, MODE_PASS, 3'd0, RAM_SRC_PC, K_MAR);
        push(S_I1, MODE_PASS, 3'd0, RAM_SRC_PC, K_MBR | K_PCI);
    endtask

    task automatic test_reset();
        obs_t r0;
        r0 = rec(S_F0, MODE_PASS, 3'd0, RAM_SRC_PC, 15'd0);
        #3;
        n_cmp++;
        if (obs !== r0) begin
            n_bad++;
            $display("FAIL reset_async got=%h exp=%h", obs, r0);
        end
        repeat (2) @(posedge cu_clk);
        #1;
        n_cmp++;
        if (obs !== r0) begin
            n_bad++;
            $display("FAIL reset_held got=%h exp=%h", obs, r0);
        end
        cu_rst_n = 1'b1;
    endtask

    task automatic test_mr();
        ent_t e;
        push_fetch(enc(OP_MR, 3'd3, 3'd5), 1'b0, 1'b0, 1'b0);
        push(S_MR0, MODE_PASS, 3'd5, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_WB,  MODE_PASS, 3'd3, RAM_SRC_PC, K_RF | K_RFMUX);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL mr st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_flags();
        ent_t e;
        // SBI with carry set, then JC must load; CM with zero set, JZ loads, JC does not.
        push_fetch(enc(OP_SBI, 3'd2, 3'd0), 1'b0, 1'b1, 1'b0);
        push_second();
        push(S_AL0, MODE_PASS, 3'd2, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_SUB,  3'd0, RAM_SRC_PC, K_ACC | K_AMUX | K_IMM);
        push(S_WB,  MODE_PASS, 3'd2, RAM_SRC_PC, K_RF | K_RFMUX);
        push_fetch(enc(OP_JC, 3'd0, 3'd0), 1'b1, 1'b0, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, K_PCL);
        push_fetch(enc(OP_CM, 3'd1, 3'd2), 1'b1, 1'b0, 1'b0);
        push(S_AL0, MODE_PASS, 3'd1, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_CMP,  3'd2, RAM_SRC_PC, K_ACC);
        push_fetch(enc(OP_JZ, 3'd0, 3'd0), 1'b0, 1'b1, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, K_PCL);
        push_fetch(enc(OP_JC, 3'd0, 3'd0), 1'b0, 1'b1, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, 15'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL flags st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        ent_t e;
        obs_t r0;
        r0 = rec(S_F0, MODE_PASS, 3'd0, RAM_SRC_PC, 15'd0);
        push_fetch(enc(OP_SUM, 3'd3, 3'd4), 1'b1, 1'b1, 1'b0);
        push(S_AL0, MODE_PASS, 3'd3, RAM_SRC_PC, K_ACC | K_AOUT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL reset_mid st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
        @(negedge cu_clk);
        n_cmp++;
        if (obs !== rec(S_AL1, MODE_ADD, 3'd4, RAM_SRC_PC, K_ACC)) begin
            n_bad++;
            $display("FAIL reset_mid_al1 got=%h exp=%h", obs,
                     rec(S_AL1, MODE_ADD, 3'd4, RAM_SRC_PC, K_ACC));
        end
        #1 cu_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== r0) begin
            n_bad++;
            $display("FAIL reset_mid_abort got=%h exp=%h", obs, r0);
        end
        @(posedge cu_clk);
        #1 cu_rst_n = 1'b1;
        // flag_z was set by the earlier CM; reset must have cleared it.
        push_fetch(enc(OP_JZ, 3'd0, 3'd0), 1'b1, 1'b1, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, 15'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL reset_mid_after st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_ld_st();
        ent_t e;
        push_fetch(enc(OP_LD, 3'd4, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_LD0, MODE_PASS, 3'd0, RAM_SRC_MBR, K_MAR);
        push(S_LD1, MODE_PASS, 3'd0, RAM_SRC_PC,  K_MBR);
        push(S_LD2, MODE_PASS, 3'd4, RAM_SRC_PC,  K_RF | K_IMM);
        push_fetch(enc(OP_ST, 3'd6, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_ST0, MODE_PASS, 3'd0, RAM_SRC_MBR, K_MAR);
        push(S_ST1, MODE_PASS, 3'd6, RAM_SRC_PC,  K_MBR | K_MBRMUX);
        push(S_ST2, MODE_PASS, 3'd0, RAM_SRC_PC,  K_RAM);
        push_fetch(enc(OP_MI, 3'd7, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_MI, MODE_PASS, 3'd7, RAM_SRC_PC, K_RF | K_IMM);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL ld_st st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        push_fetch(enc(OP_XRR, 3'd1, 3'd2), 1'b0, 1'b0, 1'b0);
        push(S_AL0, MODE_PASS, 3'd1, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_XOR,  3'd2, RAM_SRC_PC, K_ACC);
        push(S_WB,  MODE_PASS, 3'd1, RAM_SRC_PC, K_RF | K_RFMUX);
        push_fetch(enc(OP_ORI, 3'd5, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_AL0, MODE_PASS, 3'd5, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_OR,   3'd0, RAM_SRC_PC, K_ACC | K_AMUX | K_IMM);
        push(S_WB,  MODE_PASS, 3'd5, RAM_SRC_PC, K_RF | K_RFMUX);
        push_fetch(enc(OP_CMI, 3'd2, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_AL0, MODE_PASS, 3'd2, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_CMP,  3'd0, RAM_SRC_PC, K_ACC | K_AMUX | K_IMM);
        push_fetch(enc(OP_ANR, 3'd4, 3'd1), 1'b0, 1'b0, 1'b0);
        push(S_AL0, MODE_PASS, 3'd4, RAM_SRC_PC, K_ACC | K_AOUT);
        push(S_AL1, MODE_AND,  3'd1, RAM_SRC_PC, K_ACC);
        push(S_WB,  MODE_PASS, 3'd4, RAM_SRC_PC, K_RF | K_RFMUX);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL back_to_back st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        ent_t e;
        push_fetch(16'hB000, 1'b0, 1'b0, 1'b1);
        push_fetch(enc(OP_JMP, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, K_PCL);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL illegal st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    task automatic test_halt();
        ent_t e;
        obs_t r0;
        r0 = rec(S_F0, MODE_PASS, 3'd0, RAM_SRC_PC, 15'd0);
        push_fetch(enc(OP_HLT, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) push(S_HALT, MODE_PASS, 3'd0, RAM_SRC_PC, K_HALT);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL halt st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
        #2 cu_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== r0) begin
            n_bad++;
            $display("FAIL halt_reset got=%h exp=%h", obs, r0);
        end
        @(posedge cu_clk);
        #1 cu_rst_n = 1'b1;
        push_fetch(enc(OP_JMP, 3'd0, 3'd0), 1'b0, 1'b0, 1'b0);
        push_second();
        push(S_JP, MODE_PASS, 3'd0, RAM_SRC_PC, K_PCL);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.load) begin cu_in = e.din; zero = e.z; carry = e.c; end
            @(negedge cu_clk);
            n_cmp++;
            if (obs !== e.exp) begin
                n_bad++;
                $display("FAIL halt_recover st=%0d got=%h exp=%h", obs.st, obs, e.exp);
            end
            @(posedge cu_clk);
            #1;
        end
    endtask

    initial begin
        cu_rst_n = 1'b0;
        cu_in    = '0;
        zero     = 1'b0;
        carry    = 1'b0;
        test_reset();
        test_mr();
        test_flags();
        test_reset_mid();
        test_ld_st();
        test_back_to_back();
        test_illegal();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
